// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and locked line/frame timing from a raw HSYNC/VSYNC/VDE stream.
// Sync inputs are active low; lock is declared after two identical consecutive frame measurements.
module vga_sync_decoder #(
  parameter int P_CNT_W = 16
) (
  input  logic               i_CLK,
  input  logic               i_RST,
  input  logic               i_HSYNC,
  input  logic               i_VSYNC,
  input  logic               i_VDE,
  output logic               o_VDE,
  output logic [P_CNT_W-1:0] o_X_COORD,
  output logic [P_CNT_W-1:0] o_Y_COORD,
  output logic [P_CNT_W-1:0] o_H_TOTAL,
  output logic [P_CNT_W-1:0] o_V_TOTAL,
  output logic [P_CNT_W-1:0] o_H_ACTIVE,
  output logic [P_CNT_W-1:0] o_V_ACTIVE,
  output logic               o_LOCKED,
  output logic               o_FRAME_START,
  output logic               o_ERR
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_e;

  localparam logic [P_CNT_W-1:0] CNT_ONE    = {{(P_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [P_CNT_W-1:0] CNT_MAX    = {P_CNT_W{1'b1}};
  localparam logic [P_CNT_W-1:0] CNT_MAX_M1 = CNT_MAX - CNT_ONE;

  state_e             state_q, state_d;
  logic               hs_q, vs_q, vde_q, hsPrev_q, vsPrev_q;
  logic [P_CNT_W-1:0] hCnt_q, hCnt_d, vCnt_q, vCnt_d, xCnt_q, xCnt_d, yCnt_q, yCnt_d;
  logic [P_CNT_W-1:0] lineLen_q, lineLen_d, actW_q, actW_d;
  logic               linePrevValid_q, linePrevValid_d;
  logic [P_CNT_W-1:0] candH_q, candH_d, candV_q, candV_d;
  logic               candValid_q, candValid_d;
  logic               vdeOut_q;
  logic [P_CNT_W-1:0] xOut_q, yOut_q;
  logic [P_CNT_W-1:0] hTot_q, hTot_d, vTot_q, vTot_d, hAct_q, hAct_d, vAct_q, vAct_d;
  logic               err_q, err_d, frameStart_q;

  logic               hsFall, vsFall, hReach, vReach, lineMismatch;
  logic [P_CNT_W-1:0] lineLenNew, lineLenCur, frameLen, vInc, xCur, yInc;

  // Counter datapath: a coincident hs/vs fall closes the line first, then restarts the frame.
  always_comb begin
    hsFall       = hsPrev_q & ~hs_q;
    vsFall       = vsPrev_q & ~vs_q;
    lineLenNew   = hCnt_q + CNT_ONE;
    lineLenCur   = hsFall ? lineLenNew : lineLen_q;
    hCnt_d       = hsFall ? '0 : ((hCnt_q == CNT_MAX) ? hCnt_q : hCnt_q + CNT_ONE);
    hReach       = ~hsFall & (hCnt_q == CNT_MAX_M1);
    vInc         = (hsFall && vCnt_q != CNT_MAX) ? vCnt_q + CNT_ONE : vCnt_q;
    vCnt_d       = vsFall ? '0 : vInc;
    frameLen     = vInc;
    vReach       = hsFall & ~vsFall & (vCnt_q == CNT_MAX_M1);
    xCur         = hsFall ? '0 : xCnt_q;
    xCnt_d       = (vde_q && xCur != CNT_MAX) ? xCur + CNT_ONE : xCur;
    yInc         = (hsFall && xCnt_q != '0 && yCnt_q != CNT_MAX) ? yCnt_q + CNT_ONE : yCnt_q;
    yCnt_d       = vsFall ? '0 : yInc;
    actW_d       = (hsFall && xCnt_q != '0) ? xCnt_q : actW_q;
    lineMismatch = hsFall & linePrevValid_q & (lineLenNew != lineLen_q);
    lineLen_d    = lineLenCur;
    linePrevValid_d = vsFall ? 1'b0 : (hsFall ? 1'b1 : linePrevValid_q);
  end

  always_comb begin
    state_d     = state_q;
    candH_d     = candH_q;
    candV_d     = candV_q;
    candValid_d = candValid_q;
    hTot_d      = hTot_q;
    vTot_d      = vTot_q;
    hAct_d      = hAct_q;
    vAct_d      = vAct_q;
    err_d       = 1'b0;
    unique case (state_q)
      SEARCH: begin
        candValid_d = 1'b0;
        if (vsFall) state_d = MEASURE;
      end
      MEASURE: begin
        if (lineMismatch) candValid_d = 1'b0;
        if (vsFall) begin
          if (candValid_q && !lineMismatch && lineLenCur == candH_q && frameLen == candV_q) begin
            state_d = LOCKED;
            hTot_d  = lineLenCur;
            vTot_d  = frameLen;
            hAct_d  = actW_d;
            vAct_d  = yInc;
          end else begin
            candH_d     = lineLenCur;
            candV_d     = frameLen;
            candValid_d = 1'b1;
          end
        end
      end
      LOCKED: begin
        if ((hsFall && lineLenNew != hTot_q) || (vsFall && frameLen != vTot_q)) begin
          err_d       = 1'b1;
          state_d     = MEASURE;
          candValid_d = 1'b0;
        end
      end
      default: state_d = SEARCH;
    endcase
    // A runaway counter means the input is not video at all, so restart from scratch.
    if (hReach || vReach) begin
      err_d       = (state_q == LOCKED);
      state_d     = SEARCH;
      candValid_d = 1'b0;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q         <= SEARCH;
      hs_q            <= 1'b1;
      vs_q            <= 1'b1;
      vde_q           <= 1'b0;
      hsPrev_q        <= 1'b1;
      vsPrev_q        <= 1'b1;
      hCnt_q          <= '0;
      vCnt_q          <= '0;
      xCnt_q          <= '0;
      yCnt_q          <= '0;
      lineLen_q       <= '0;
      actW_q          <= '0;
      linePrevValid_q <= 1'b0;
      candH_q         <= '0;
      candV_q         <= '0;
      candValid_q     <= 1'b0;
      vdeOut_q        <= 1'b0;
      xOut_q          <= '0;
      yOut_q          <= '0;
      hTot_q          <= '0;
      vTot_q          <= '0;
      hAct_q          <= '0;
      vAct_q          <= '0;
      err_q           <= 1'b0;
      frameStart_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      hs_q            <= i_HSYNC;
      vs_q            <= i_VSYNC;
      vde_q           <= i_VDE;
      hsPrev_q        <= hs_q;
      vsPrev_q        <= vs_q;
      hCnt_q          <= hCnt_d;
      vCnt_q          <= vCnt_d;
      xCnt_q          <= xCnt_d;
      yCnt_q          <= yCnt_d;
      lineLen_q       <= lineLen_d;
      actW_q          <= actW_d;
      linePrevValid_q <= linePrevValid_d;
      candH_q         <= candH_d;
      candV_q         <= candV_d;
      candValid_q     <= candValid_d;
      vdeOut_q        <= vde_q;
      xOut_q          <= xCur;
      yOut_q          <= yCnt_d;
      hTot_q          <= hTot_d;
      vTot_q          <= vTot_d;
      hAct_q          <= hAct_d;
      vAct_q          <= vAct_d;
      err_q           <= err_d;
      frameStart_q    <= vsFall;
    end
  end

  assign o_VDE         = vdeOut_q;
  assign o_X_COORD     = xOut_q;
  assign o_Y_COORD     = yOut_q;
  assign o_H_TOTAL     = hTot_q;
  assign o_V_TOTAL     = vTot_q;
  assign o_H_ACTIVE    = hAct_q;
  assign o_V_ACTIVE    = vAct_q;
  assign o_LOCKED      = (state_q == LOCKED);
  assign o_FRAME_START = frameStart_q;
  assign o_ERR         = err_q;

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter P_CNT_W, default 16, width of all counters and measured values.
REQ-002 SHALL have port i_CLK  input  1  pixel clock; all logic on its rising edge.
REQ-003 SHALL have port i_RST  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_HSYNC  input  1  horizontal sync, active low.
REQ-005 SHALL have port i_VSYNC  input  1  vertical sync, active low.
REQ-006 SHALL have port i_VDE  input  1  video data enable, active high.
REQ-007 SHALL have port o_VDE  output  1  i_VDE delayed to align with the coordinates.
REQ-008 SHALL have port o_X_COORD  output  P_CNT_W  pixel index within the active line.
REQ-009 SHALL have port o_Y_COORD  output  P_CNT_W  active-line index within the frame.
REQ-010 SHALL have port o_H_TOTAL / o_V_TOTAL  output  P_CNT_W each  locked clocks per line / lines per frame.
REQ-011 SHALL have port o_H_ACTIVE / o_V_ACTIVE  output  P_CNT_W each  locked active pixels per line / active lines per frame.
REQ-012 SHALL have port o_LOCKED  output  1  timing stable.
REQ-013 SHALL have port o_FRAME_START  output  1  one-cycle pulse per detected VSYNC falling edge.
REQ-014 SHALL have port o_ERR  output  1  one-cycle pulse on loss of lock.

Function
REQ-015 SHALL register i_HSYNC, i_VSYNC and i_VDE once; edge detection compares this stage with its previous value (hs_fall, vs_fall).
REQ-016 SHALL run h_cnt: cleared on hs_fall, otherwise incremented by 1, saturating at all-ones; line length = h_cnt+1, captured on hs_fall.
REQ-017 SHALL run v_cnt: incremented on hs_fall, cleared on vs_fall; frame length = v_cnt (plus 1 if hs_fall is in the same cycle), captured on vs_fall.
REQ-018 SHALL run x_cnt: incremented each cycle the registered VDE is high, cleared on hs_fall; o_X_COORD = x_cnt before the increment, so the first active pixel is 0.
REQ-019 SHALL run y_cnt: incremented on hs_fall only if the line just ended had at least one VDE-high cycle, cleared on vs_fall; drives o_Y_COORD.
REQ-020 SHALL give o_VDE, o_X_COORD, o_Y_COORD a latency of exactly 2 clocks from the i_VDE pin; coordinates decode whether or not locked.
REQ-021 SHALL capture active width on hs_fall (x_cnt, if nonzero) and active height on vs_fall (y_cnt).
REQ-022 SHALL implement FSM SEARCH, MEASURE, LOCKED; reset state SEARCH.
REQ-023 SEARCH: on first vs_fall go to MEASURE; clear candidate-valid.
REQ-024 MEASURE: on vs_fall, if candidate valid and captured (line length, frame length) equal the candidate, go to LOCKED and load o_H_TOTAL/o_V_TOTAL/o_H_ACTIVE/o_V_ACTIVE; otherwise store the new pair as candidate, set candidate-valid, and stay.
REQ-025 MEASURE: a line length that differs from the previous line in the same frame SHALL clear candidate-valid.
REQ-026 LOCKED: any hs_fall line length or vs_fall frame length not equal to o_H_TOTAL/o_V_TOTAL SHALL pulse o_ERR, drop o_LOCKED, clear candidate-valid and go to MEASURE.
REQ-027 h_cnt or v_cnt reaching saturation SHALL pulse o_ERR (if LOCKED) and go to SEARCH.
REQ-028 hs_fall and vs_fall in the same cycle SHALL close the line before the frame (line counted, then y/v cleared).
REQ-029 o_LOCKED SHALL be high exactly when the state is LOCKED; o_H_TOTAL/o_V_TOTAL/o_H_ACTIVE/o_V_ACTIVE hold their last locked values after lock loss.

Reset
REQ-030 With i_RST high at a clock edge, all counters, the candidate, the registered inputs (syncs to 1, VDE to 0) and all outputs SHALL be 0 after that edge, state SEARCH; reset mid-frame discards partial measurements.

Verification
REQ-031 Ideal 800x525 stream, 640x480 active -> o_LOCKED rises at the third vs_fall after reset; o_H_TOTAL=800, o_V_TOTAL=525, o_H_ACTIVE=640, o_V_ACTIVE=480.
REQ-032 Same stream -> first active pixel gives o_VDE=1, X=0, Y=0 two clocks after i_VDE; last gives X=639, Y=479.
REQ-033 While locked, one line stretched to 801 -> o_ERR one-cycle pulse, o_LOCKED=0; relock at the second following vs_fall.
REQ-034 i_HSYNC held high for 65535 clocks while locked -> o_ERR pulse, state SEARCH, o_LOCKED=0.
REQ-035 i_RST for 1 cycle mid-frame -> all outputs 0 next cycle; relock after three vs_falls.
REQ-036 hs_fall coincident with vs_fall -> V_TOTAL counts that line (525) and Y restarts at 0.
